// File: rtl/player_motion.sv
// ---------------------------------------------------------------------------
// player_motion
//
// Purpose:
//     Per-frame player motion controller. On every frame tick it works out
//     the candidate move from the walk buttons and gravity, then asks the
//     collision checker about the horizontal and the vertical move one after
//     the other (one start/done handshake each). The move is committed from
//     the contact flags that come back.
//
// Configuration macro:
//     SCREEN_CLAMP_EN - when defined, candidate positions are clamped to the
//                       visible screen (x 0..639, y 0..479) and the bottom
//                       edge acts as a floor. When undefined, candidates wrap
//                       modulo the register width.
//
// Ports:
//     clk_i            system clock
//     reset_i          synchronous, active-high reset
//     frame_tick_i     one-cycle pulse per video frame
//     btn_left_i       walk left (level)
//     btn_right_i      walk right (level)
//     btn_jump_i       jump request, sampled on frame_tick_i
//     coll_start_o     probe request to the collision block
//     coll_redo_o      restart the object scan (first probe of a frame)
//     coll_x_o         probed x (10 bits)
//     coll_y_o         probed y (9 bits)
//     coll_done_i      probe finished, contact flags valid while high
//     coll_up_i        contact above the probed position
//     coll_down_i      contact below the probed position
//     coll_left_i      contact left of the probed position
//     coll_right_i     contact right of the probed position
//     x_o              committed x (10 bits)
//     y_o              committed y (9 bits)
//     on_ground_o      player resting on a surface
//     busy_o           probe sequence in progress
//     frame_overrun_o  one-cycle pulse when a tick arrives while busy
// ---------------------------------------------------------------------------
module player_motion #(
    parameter int WALK_V   = 2,
    parameter int JUMP_V   = 8,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 7,
    parameter int TIMEOUT  = 255,
    parameter int X0       = 100,
    parameter int Y0       = 100
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_tick_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic       btn_jump_i,
    output logic       coll_start_o,
    output logic       coll_redo_o,
    output logic [9:0] coll_x_o,
    output logic [8:0] coll_y_o,
    input  logic       coll_done_i,
    input  logic       coll_up_i,
    input  logic       coll_down_i,
    input  logic       coll_left_i,
    input  logic       coll_right_i,
    output logic [9:0] x_o,
    output logic [8:0] y_o,
    output logic       on_ground_o,
    output logic       busy_o,
    output logic       frame_overrun_o
);

    localparam int FALL_LIMIT = MAX_FALL - GRAVITY;
    localparam int TIMEOUT_LAST = TIMEOUT - 1;

    localparam logic signed [3:0] WALK_S       = WALK_V[3:0];
    localparam logic signed [5:0] JUMP_S       = JUMP_V[5:0];
    localparam logic signed [5:0] GRAV_S       = GRAVITY[5:0];
    localparam logic signed [5:0] FALL_S       = MAX_FALL[5:0];
    localparam logic signed [5:0] FALL_LIMIT_S = FALL_LIMIT[5:0];
    localparam logic [7:0]        TIMEOUT_LAST_C = TIMEOUT_LAST[7:0];
    localparam logic [9:0]        X0_C = X0[9:0];
    localparam logic [8:0]        Y0_C = Y0[8:0];
`ifdef SCREEN_CLAMP_EN
    localparam logic [9:0]        X_MAX = 10'd639;
    localparam logic [8:0]        Y_MAX = 9'd479;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        PROBE_X,
        GAP,
        PROBE_Y,
        COMMIT
    } state_t;

    state_t            state_q;
    logic [9:0]        posX_q;
    logic [8:0]        posY_q;
    logic signed [5:0] vy_q;
    logic signed [3:0] vx_q;
    logic              onGround_q;
    logic              collStart_q;
    logic              collRedo_q;
    logic [9:0]        collX_q;
    logic [8:0]        collY_q;
    logic              busy_q;
    logic              overrun_q;
    logic [7:0]        waitCnt_q;

    logic signed [3:0] vx_d;
    logic [9:0]        candX_d;
    logic [8:0]        candY_d;
    logic              probeEnd;
    logic              effUp;
    logic              effDown;
    logic              effLeft;
    logic              effRight;
    logic              blockedX;

    // Horizontal speed from the walk buttons; pressing both means stand still.
    always_comb begin
        vx_d = 4'sd0;
        if (btn_right_i && !btn_left_i) begin
            vx_d = WALK_S;
        end else if (btn_left_i && !btn_right_i) begin
            vx_d = -WALK_S;
        end
    end

    // Candidate positions. x+vx is formed from the committed x (CALC) and
    // y+vy from the committed y (GAP), both evaluated in signed 12 bits.
`ifdef SCREEN_CLAMP_EN
    logic signed [11:0] sumX;
    logic signed [11:0] sumY;

    always_comb begin
        sumX    = $signed({2'b00, posX_q}) + {{8{vx_q[3]}}, vx_q};
        sumY    = $signed({3'b000, posY_q}) + {{6{vy_q[5]}}, vy_q};
        candX_d = sumX[9:0];
        candY_d = sumY[8:0];
        if (sumX < 12'sd0) begin
            candX_d = 10'd0;
        end else if (sumX > 12'sd639) begin
            candX_d = X_MAX;
        end
        if (sumY < 12'sd0) begin
            candY_d = 9'd0;
        end else if (sumY > 12'sd479) begin
            candY_d = Y_MAX;
        end
    end
`else
    // Modular add at the register width is the same as truncating the
    // 12-bit sum, so the wrap-around comes for free.
    always_comb begin
        candX_d = posX_q + {{6{vx_q[3]}}, vx_q};
        candY_d = posY_q + {{3{vy_q[5]}}, vy_q};
    end
`endif

    // A probe ends on coll_done or after TIMEOUT silent cycles. A timed-out
    // probe reports contact on every side, so nothing moves into unknown space.
    always_comb begin
        probeEnd = coll_done_i || (waitCnt_q == TIMEOUT_LAST_C);
        effUp    = coll_done_i ? coll_up_i    : 1'b1;
        effDown  = coll_done_i ? coll_down_i  : 1'b1;
        effLeft  = coll_done_i ? coll_left_i  : 1'b1;
        effRight = coll_done_i ? coll_right_i : 1'b1;
        blockedX = ((vx_q > 4'sd0) && effRight) || ((vx_q < 4'sd0) && effLeft);
    end

    // Frame sequencer: IDLE -> CALC -> PROBE_X -> GAP -> PROBE_Y -> COMMIT.
    // GAP is the single cycle with coll_start low between the two probes.
    // All handshake outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            posX_q      <= X0_C;
            posY_q      <= Y0_C;
            vy_q        <= 6'sd0;
            vx_q        <= 4'sd0;
            onGround_q  <= 1'b0;
            collStart_q <= 1'b0;
            collRedo_q  <= 1'b0;
            collX_q     <= X0_C;
            collY_q     <= Y0_C;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            waitCnt_q   <= 8'd0;
        end else begin
            collRedo_q <= 1'b0;
            overrun_q  <= frame_tick_i && (state_q != IDLE);

            unique case (state_q)
                IDLE: begin
                    if (frame_tick_i) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        vx_q    <= vx_d;
                        if (btn_jump_i && onGround_q) begin
                            vy_q       <= -JUMP_S;
                            onGround_q <= 1'b0;
                        end else if (vy_q >= FALL_LIMIT_S) begin
                            vy_q <= FALL_S;
                        end else begin
                            vy_q <= vy_q + GRAV_S;
                        end
                    end
                end

                CALC: begin
                    collX_q     <= candX_d;
                    collY_q     <= posY_q;
                    collStart_q <= 1'b1;
                    collRedo_q  <= 1'b1;
                    waitCnt_q   <= 8'd0;
                    state_q     <= PROBE_X;
                end

                PROBE_X: begin
                    if (probeEnd) begin
                        if (!blockedX) begin
                            posX_q <= collX_q;
                        end
                        collStart_q <= 1'b0;
                        state_q     <= GAP;
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end

                GAP: begin
                    collX_q     <= posX_q;
                    collY_q     <= candY_d;
                    collStart_q <= 1'b1;
                    waitCnt_q   <= 8'd0;
                    state_q     <= PROBE_Y;
                end

                PROBE_Y: begin
                    if (probeEnd) begin
                        if ((vy_q > 6'sd0) && effDown) begin
                            vy_q       <= 6'sd0;
                            onGround_q <= 1'b1;
                        end else if ((vy_q < 6'sd0) && effUp) begin
                            vy_q <= 6'sd0;
                        end else begin
                            posY_q     <= collY_q;
                            onGround_q <= (vy_q == 6'sd0) && effDown;
`ifdef SCREEN_CLAMP_EN
                            // The bottom screen edge is a floor.
                            if ((vy_q > 6'sd0) && (collY_q == Y_MAX)) begin
                                onGround_q <= 1'b1;
                                vy_q       <= 6'sd0;
                            end
`endif
                        end
                        collStart_q <= 1'b0;
                        state_q     <= COMMIT;
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end

                COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign coll_start_o    = collStart_q;
    assign coll_redo_o     = collRedo_q;
    assign coll_x_o        = collX_q;
    assign coll_y_o        = collY_q;
    assign x_o             = posX_q;
    assign y_o             = posY_q;
    assign on_ground_o     = onGround_q;
    assign busy_o          = busy_q;
    assign frame_overrun_o = overrun_q;

endmodule
